// File: rtl/bidir_pkg.sv
// Shared definitions for the bidirectional bus controller: state encoding and
// the per-bit output-enable levels replicated across the pad width.
package bidir_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TURN  = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_RCAP  = 3'd4
  } state_t;

  localparam logic OE_ALL  = 1'b1;
  localparam logic OE_NONE = 1'b0;

endpackage

// File: rtl/bidir_bus_ctrl.sv
// Half-duplex bus master feeding a registered bidirectional pad stage: turns
// single-word requests into turnaround + strobed data phases and returns reads.
module bidir_bus_ctrl
  import bidir_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int TURN   = 1,
  parameter int WAIT_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [SIZE-1:0]   i_req_wdata,
  input  logic [WAIT_W-1:0] i_cfg_wait,
  output logic              o_rd_valid,
  output logic [SIZE-1:0]   o_rd_data,
  output logic              o_bus_strb,
  output logic [SIZE-1:0]   o_pad_oe,
  output logic [SIZE-1:0]   o_pad_inp,
  input  logic [SIZE-1:0]   i_pad_outp
);

  localparam int TURN_W = $clog2(TURN + 1);
  localparam int CNT_W  = (WAIT_W > TURN_W) ? WAIT_W : TURN_W;
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_wr;
  logic              w_wr_nxt;
  logic [WAIT_W-1:0] r_n;
  logic [WAIT_W-1:0] w_n_nxt;
  logic              r_req_ready;
  logic              w_req_ready_nxt;
  logic              r_rd_valid;
  logic              w_rd_valid_nxt;
  logic [SIZE-1:0]   r_rd_data;
  logic [SIZE-1:0]   w_rd_data_nxt;
  logic              r_bus_strb;
  logic              w_bus_strb_nxt;
  logic [SIZE-1:0]   r_pad_oe;
  logic [SIZE-1:0]   w_pad_oe_nxt;
  logic [SIZE-1:0]   r_pad_inp;
  logic [SIZE-1:0]   w_pad_inp_nxt;
  logic              w_accept;
  logic              w_cnt_zero;

  assign w_accept   = i_req_valid & r_req_ready;
  assign w_cnt_zero = (r_cnt == '0);

  // The counter holds remaining cycles minus one, so a phase ends when it reads zero.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_wr_nxt       = r_wr;
    w_n_nxt        = r_n;
    w_pad_inp_nxt  = r_pad_inp;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_TURN;
          w_cnt_nxt   = TURN_LOAD;
          w_wr_nxt    = i_req_wr;
          w_n_nxt     = (i_cfg_wait == '0) ? WAIT_W'(1) : i_cfg_wait;
          // Load write data now so the pad register holds it before oe rises.
          if (i_req_wr) begin
            w_pad_inp_nxt = i_req_wdata;
          end else begin
            w_pad_inp_nxt = r_pad_inp;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TURN: begin
        if (w_cnt_zero) begin
          w_state_nxt = r_wr ? S_WDATA : S_RDATA;
          w_cnt_nxt   = CNT_W'(r_n) - CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_WDATA, S_RDATA: begin
        if (w_cnt_zero) begin
          w_state_nxt = (r_state == S_WDATA) ? S_IDLE : S_RCAP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RCAP: begin
        // Pad output register already holds the pin as seen at the last data edge.
        w_state_nxt    = S_IDLE;
        w_rd_data_nxt  = i_pad_outp;
        w_rd_valid_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output values decoded from the next state so registered outputs align with it.
  always_comb begin
    w_req_ready_nxt = (w_state_nxt == S_IDLE);
    w_bus_strb_nxt  = (w_state_nxt == S_WDATA) || (w_state_nxt == S_RDATA);
    if (w_state_nxt == S_WDATA) begin
      w_pad_oe_nxt = {SIZE{OE_ALL}};
    end else begin
      w_pad_oe_nxt = {SIZE{OE_NONE}};
    end
  end

  // State, phase counter, latched request and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_n         <= WAIT_W'(1);
      r_req_ready <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_bus_strb  <= 1'b0;
      r_pad_oe    <= {SIZE{OE_NONE}};
      r_pad_inp   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wr        <= w_wr_nxt;
      r_n         <= w_n_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_bus_strb  <= w_bus_strb_nxt;
      r_pad_oe    <= w_pad_oe_nxt;
      r_pad_inp   <= w_pad_inp_nxt;
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_bus_strb  = r_bus_strb;
  assign o_pad_oe    = r_pad_oe;
  assign o_pad_inp   = r_pad_inp;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Bench for bidir_bus_ctrl: registered pad model plus bus-side driver, with a
// scoreboard of issued requests checked against strobe, pin and read-return timing.
module tb_bidir_bus_ctrl;

  localparam int SIZE   = 8;
  localparam int TURN   = 1;
  localparam int WAIT_W = 4;

  typedef struct {
    logic            wr;
    logic [SIZE-1:0] d;
    int              n;
    int              acc;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_wr;
  logic [SIZE-1:0]   req_wdata;
  logic [WAIT_W-1:0] cfg_wait;
  logic              req_ready;
  logic              rd_valid;
  logic [SIZE-1:0]   rd_data;
  logic              bus_strb;
  logic [SIZE-1:0]   pad_oe;
  logic [SIZE-1:0]   pad_inp;

  logic [SIZE-1:0] pad_oe_r   = '0;
  logic [SIZE-1:0] pad_inp_r  = '0;
  logic [SIZE-1:0] pad_outp_r = '0;
  logic [SIZE-1:0] bus_val    = '0;
  logic [SIZE-1:0] pin;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  txn_t sb[$];

  always #5 clk = ~clk;

  bidir_bus_ctrl #(.SIZE(SIZE), .TURN(TURN), .WAIT_W(WAIT_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_wr    (req_wr),
    .i_req_wdata (req_wdata),
    .i_cfg_wait  (cfg_wait),
    .o_rd_valid  (rd_valid),
    .o_rd_data   (rd_data),
    .o_bus_strb  (bus_strb),
    .o_pad_oe    (pad_oe),
    .o_pad_inp   (pad_inp),
    .i_pad_outp  (pad_outp_r)
  );

  // Pad stage: oe/inp registered toward the pin, pin registered back as outp.
  always_comb pin = (pad_oe_r & pad_inp_r) | (~pad_oe_r & bus_val);

  always @(posedge clk) begin
    pad_oe_r   <= pad_oe;
    pad_inp_r  <= pad_inp;
    pad_outp_r <= pin;
    cyc        <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: pops scoreboard entries as strobe phases and read returns appear.
  logic prev_strb = 1'b0;
  logic prev_rdv  = 1'b0;
  int   strb_len  = 0;
  logic [SIZE-1:0] last_w = '0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_strb = 1'b0;
      prev_rdv  = 1'b0;
      strb_len  = 0;
      last_w    = '0;
    end else begin
      check_val("oe_uniform", 32'(pad_oe == 8'h00 || pad_oe == 8'hFF), 32'd1);
      if (pad_oe != 8'h00) check_val("oe_without_strb", 32'(bus_strb), 32'd1);
      if (req_ready) check_val("pad_inp_hold", 32'(pad_inp), 32'(last_w));
      if (pad_oe_r != 8'h00) check_val("pin_wdata", 32'(pin), 32'(last_w));
      if (bus_strb && !prev_strb) begin
        if (sb.size() == 0) begin
          check_val("strb_unexpected", 32'd1, 32'd0);
        end else begin
          check_val("strb_start", 32'(cyc - sb[0].acc), 32'(TURN));
          check_val("strb_oe", 32'(pad_oe), sb[0].wr ? 32'hFF : 32'h00);
          if (sb[0].wr) last_w = sb[0].d;
          strb_len = 0;
        end
      end
      if (bus_strb) strb_len++;
      if (!bus_strb && prev_strb && sb.size() > 0) begin
        check_val("strb_len", 32'(strb_len), 32'(sb[0].n));
        if (sb[0].wr) begin
          check_val("wr_ready_back", 32'(req_ready), 32'd1);
          void'(sb.pop_front());
        end
      end
      if (rd_valid) begin
        if (prev_rdv) check_val("rdv_pulse_width", 32'd2, 32'd1);
        if (sb.size() == 0 || sb[0].wr) begin
          check_val("rdv_unexpected", 32'd1, 32'd0);
        end else begin
          check_val("rd_data", 32'(rd_data), 32'(sb[0].d));
          check_val("rd_latency", 32'(cyc - sb[0].acc), 32'(TURN + sb[0].n + 1));
          void'(sb.pop_front());
        end
      end
      prev_strb = bus_strb;
      prev_rdv  = rd_valid;
    end
  end

  // Called on a negedge; returns on the negedge after the accept edge.
  task automatic issue(input logic wr, input logic [SIZE-1:0] d, input logic [WAIT_W-1:0] w,
                       input logic [SIZE-1:0] bv, input logic hold);
    int   t;
    txn_t x;
    req_valid = 1'b1;
    req_wr    = wr;
    req_wdata = d;
    cfg_wait  = w;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check_val("accept_timeout", 32'd0, 32'd1);
    end else begin
      x.wr  = wr;
      x.d   = wr ? d : bv;
      x.n   = (w == '0) ? 1 : int'(w);
      x.acc = cyc + 1;
      if (!wr) bus_val = bv;
      sb.push_back(x);
      @(negedge clk);
      if (wr) check_val("inp_in_turn", 32'(pad_inp), 32'(d));
      check_val("ready_drop", 32'(req_ready), 32'd0);
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check_val("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check_val({tag, "_oe"}, 32'(pad_oe), 32'h00);
    check_val({tag, "_strb"}, 32'(bus_strb), 32'd0);
    check_val({tag, "_ready"}, 32'(req_ready), 32'd1);
    check_val({tag, "_rdv"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_wdata = '0; cfg_wait = '0;
    repeat (2) @(negedge clk);
    reset_checks("por");
    check_val("por_rd_data", 32'(rd_data), 32'd0);
    check_val("por_pad_inp", 32'(pad_inp), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write and read with documented timing.
    issue(1'b1, 8'hA5, 4'd2, 8'h00, 1'b0);
    wait_idle();
    issue(1'b0, 8'h00, 4'd3, 8'h3C, 1'b0);
    wait_idle();
    check_val("rd_data_held", 32'(rd_data), 32'h3C);

    // Zero wait is treated as a single-cycle data phase.
    issue(1'b1, 8'h5A, 4'd0, 8'h00, 1'b0);
    wait_idle();
    issue(1'b0, 8'h00, 4'd0, 8'hC3, 1'b0);
    wait_idle();

    // Back-to-back mixed requests with req_valid held, including maximum wait.
    issue(1'b1, 8'h0F, 4'd2, 8'h00, 1'b1);
    issue(1'b0, 8'h00, 4'd1, 8'hF0, 1'b1);
    issue(1'b1, 8'h99, 4'd15, 8'h00, 1'b1);
    issue(1'b1, 8'h42, 4'd1, 8'h00, 1'b1);
    issue(1'b0, 8'h00, 4'd15, 8'h66, 1'b0);
    wait_idle();

    // Reset for three cycles in the middle of a write data phase.
    issue(1'b1, 8'hE7, 4'd6, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("rst_wr");
    repeat (2) @(negedge clk);
    check_val("rst_hold_oe", 32'(pad_oe), 32'h00);
    rst = 1'b0;
    @(negedge clk);

    // Reset during a read data phase must suppress the read return.
    issue(1'b0, 8'h00, 4'd4, 8'h77, 1'b0);
    @(negedge clk);
    check_val("rd_phase_strb", 32'(bus_strb), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("rst_rd");
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_val("rst_rd_no_rdv", 32'(rd_valid), 32'd0);
    end

    // Recovery after reset.
    issue(1'b0, 8'h00, 4'd2, 8'hA1, 1'b0);
    wait_idle();
    issue(1'b1, 8'h3D, 4'd3, 8'h00, 1'b0);
    wait_idle();

    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
